// File: rtl/tow_pkg.sv
// Shared Tug-of-War types: debounce FSM state encoding and default timing constants.
package tow_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM_HI = 2'd1,
        HIGH   = 2'd2,
        ARM_LO = 2'd3
    } state_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    // Debounced level is high while stable-high or while a release is still unconfirmed.
    function automatic logic level_of(input state_t s);
        return (s == HIGH) || (s == ARM_LO);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Metastability synchronizer: shifts the async input through STAGES flops.
// Latency STAGES edges; no backpressure (free-running).
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    output logic sync
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], push};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync = sync_q[STAGES-1];

endmodule

// File: rtl/push_debounce.sv
// Pushbutton conditioner: synchronizer + debounce FSM producing clean level sypush.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges per level change; no backpressure.
module push_debounce
    import tow_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 16,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    output logic                sypush,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                sync;
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                sypush_q, sypush_d;
    logic                busy_q, busy_d;
    logic                glitch_inc;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .sync (sync)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        glitch_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d = ARM_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            ARM_HI: begin
                if (!sync) begin
                    state_d    = IDLE;
                    glitch_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (!sync) begin
                    state_d = ARM_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            ARM_LO: begin
                if (sync) begin
                    state_d    = HIGH;
                    glitch_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Saturate rather than wrap so a noisy button never reads as a quiet one.
        glitch_d = glitch_q;
        if (glitch_inc && (glitch_q != {GLITCH_W{1'b1}})) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end

        sypush_d = level_of(state_d);
        busy_d   = (state_d == ARM_HI) || (state_d == ARM_LO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            glitch_q <= '0;
            sypush_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
            sypush_q <= sypush_d;
            busy_q   <= busy_d;
        end
    end

    assign sypush     = sypush_q;
    assign busy       = busy_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_push_debounce.sv
// Directed bench for push_debounce: reset, clean press/release, bounces, saturation, mid-run reset.
module tb_push_debounce;

    logic       clk;
    logic       rst;
    logic       push;
    logic       sypush;
    logic       busy;
    logic [7:0] glitch_cnt;
    logic       push_s;
    logic       sypush_s;
    logic       busy_s;
    logic [1:0] glitch_cnt_s;

    int total;
    int bad;

    push_debounce dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .sypush     (sypush),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    push_debounce #(
        .GLITCH_W (2)
    ) dut_s (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .sypush     (sypush_s),
        .busy       (busy_s),
        .glitch_cnt (glitch_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs changed after this are seen by the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        push   = 1'b1;
        push_s = 1'b0;
        #2;
        for (int k = 1; k <= 5; k++) begin
            step();
            total++;
            if (sypush !== 1'b0 || busy !== 1'b0 || glitch_cnt !== 8'd0) begin
                bad++;
                $display("FAIL reset edge %0d: sypush=%b busy=%b glitch=%0d want 0/0/0",
                         k, sypush, busy, glitch_cnt);
            end
        end
        push = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step();
        total++;
        if (sypush !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: sypush=%b busy=%b want 0/0", sypush, busy);
        end
    endtask

    task automatic test_clean_press();
        logic exp_s, exp_b;
        push = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_s = (k >= 6);
            exp_b = (k >= 3 && k <= 5);
            total++;
            if (sypush !== exp_s || busy !== exp_b) begin
                bad++;
                $display("FAIL press edge %0d: sypush=%b busy=%b want %b/%b",
                         k, sypush, busy, exp_s, exp_b);
            end
        end
        push = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_s = (k < 6);
            exp_b = (k >= 3 && k <= 5);
            total++;
            if (sypush !== exp_s || busy !== exp_b) begin
                bad++;
                $display("FAIL release edge %0d: sypush=%b busy=%b want %b/%b",
                         k, sypush, busy, exp_s, exp_b);
            end
        end
        total++;
        if (glitch_cnt !== 8'd0) begin
            bad++;
            $display("FAIL clean_glitch: glitch=%0d want 0", glitch_cnt);
        end
    endtask

    task automatic test_bounce();
        logic exp_s;
        logic prev;
        int   rises;
        rises = 0;
        prev  = sypush;
        // Edge 1..2 high, 3..5 low, 6.. high: final rise is edge 6, sypush after edge 11.
        for (int k = 1; k <= 14; k++) begin
            push = (k <= 2) || (k >= 6);
            step();
            if (sypush === 1'b1 && prev === 1'b0) rises++;
            prev  = sypush;
            exp_s = (k >= 11);
            total++;
            if (sypush !== exp_s) begin
                bad++;
                $display("FAIL bounce edge %0d: sypush=%b want %b", k, sypush, exp_s);
            end
        end
        total++;
        if (glitch_cnt !== 8'd1) begin
            bad++;
            $display("FAIL bounce_glitch: glitch=%0d want 1", glitch_cnt);
        end
        total++;
        if (rises != 1) begin
            bad++;
            $display("FAIL bounce_rises: rises=%0d want 1", rises);
        end
    endtask

    task automatic test_release_bounce();
        logic exp_s;
        for (int k = 1; k <= 14; k++) begin
            push = !((k <= 2) || (k >= 6));
            step();
            exp_s = (k < 11);
            total++;
            if (sypush !== exp_s) begin
                bad++;
                $display("FAIL rel_bounce edge %0d: sypush=%b want %b", k, sypush, exp_s);
            end
        end
        total++;
        if (glitch_cnt !== 8'd2) begin
            bad++;
            $display("FAIL rel_bounce_glitch: glitch=%0d want 2", glitch_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_g;
        for (int i = 0; i < 5; i++) begin
            for (int k = 1; k <= 5; k++) begin
                push_s = (k <= 2);
                step();
            end
            exp_g = (i >= 2) ? 2'd3 : 2'(i + 1);
            total++;
            if (glitch_cnt_s !== exp_g || sypush_s !== 1'b0) begin
                bad++;
                $display("FAIL saturation abort %0d: glitch=%0d sypush=%b want %0d/0",
                         i + 1, glitch_cnt_s, sypush_s, exp_g);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic exp_s;
        push = 1'b1;
        for (int k = 1; k <= 4; k++) step();
        total++;
        if (busy !== 1'b1 || sypush !== 1'b0) begin
            bad++;
            $display("FAIL mid_arm: busy=%b sypush=%b want 1/0", busy, sypush);
        end
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || sypush !== 1'b0 || glitch_cnt !== 8'd0) begin
            bad++;
            $display("FAIL mid_reset_async: busy=%b sypush=%b glitch=%0d want 0/0/0",
                     busy, sypush, glitch_cnt);
        end
        step();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_s = (k >= 6);
            total++;
            if (sypush !== exp_s) begin
                bad++;
                $display("FAIL post_reset edge %0d: sypush=%b want %b", k, sypush, exp_s);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_saturation();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
